// File: rtl/sum_accumulator.sv
// Accumulates blocks of COUNT upstream adder sums into one ACC_W-bit total
// with a sticky wrap flag, behind valid/ready handshakes on both sides.
module sum_accumulator #(
    parameter int N     = 3,
    parameter int COUNT = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N:0]       in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   sum_ext;
    logic             ovf_nxt;
    logic             accept;

    // Bit ACC_W of the result is the carry out of the modulo-2^ACC_W add.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [N:0]       b);
        return {1'b0, a} + {{(ACC_W - N){1'b0}}, b};
    endfunction

    // Handshake flags decode registered state only, so no input-to-output paths.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign sum_ext   = acc_add(acc, in_sum);
    assign ovf_nxt   = ovf | sum_ext[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= sum_ext[ACC_W-1:0];
                        ovf <= ovf_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state   <= DONE;
                            out_acc <= sum_ext[ACC_W-1:0];
                            out_ovf <= ovf_nxt;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Drain cycle: no input accepted, result registers keep their value.
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build, ACC_W=5 build sharing its
// stimulus, and a COUNT=1 build driven separately.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] in_sum;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_a, out_ovf_a, out_valid_a;
    logic [5:0] out_acc_a;
    logic       in_ready_b, out_ovf_b, out_valid_b;
    logic [4:0] out_acc_b;

    logic       clr_c;
    logic [3:0] in_sum_c;
    logic       in_valid_c, out_ready_c;
    logic       in_ready_c, out_ovf_c, out_valid_c;
    logic [5:0] out_acc_c;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.N(3), .COUNT(4), .ACC_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(in_ready_a), .out_acc(out_acc_a), .out_ovf(out_ovf_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    sum_accumulator #(.N(3), .COUNT(4), .ACC_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_sum(in_sum), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_acc(out_acc_b), .out_ovf(out_ovf_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    sum_accumulator #(.N(3), .COUNT(1), .ACC_W(6)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .in_sum(in_sum_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .out_acc(out_acc_c), .out_ovf(out_ovf_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One beat presented for exactly one clock edge; outputs sampled 1ns after.
    task automatic push(input logic [3:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_sum = '0; in_valid = 1'b0; out_ready = 1'b0;
        clr_c = 1'b0; in_sum_c = '0; in_valid_c = 1'b0; out_ready_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_acc", out_acc_a, 0);
        chk("rst_out_ovf", out_ovf_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready_a, 1);

        // Back-to-back block, downstream always ready
        @(negedge clk);
        out_ready = 1'b1;
        push(9); push(6); push(9);
        chk("t1_no_valid_early", out_valid_a, 0);
        push(8);
        chk("t1_out_valid", out_valid_a, 1);
        chk("t1_out_acc", out_acc_a, 32);
        chk("t1_out_ovf", out_ovf_a, 0);
        chk("t1_in_ready_low", in_ready_a, 0);
        chk("t2_wrap_acc", out_acc_b, 0);
        chk("t2_wrap_ovf", out_ovf_b, 1);
        idle_cycle();
        chk("t1_drain_valid", out_valid_a, 0);
        chk("t1_drain_in_ready", in_ready_a, 1);
        chk("t1_drain_keep_acc", out_acc_a, 32);

        // Sticky overflow must not leak into the next block
        push(1); push(1); push(1); push(1);
        chk("t2_next_acc", out_acc_b, 4);
        chk("t2_next_ovf", out_ovf_b, 0);
        chk("t2_next_valid", out_valid_b, 1);
        idle_cycle();

        // Backpressure in DONE while upstream keeps offering beats
        out_ready = 1'b0;
        push(9); push(6); push(9); push(8);
        in_valid = 1'b1;
        in_sum   = 7;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            chk("t3_hold_acc", out_acc_a, 32);
            chk("t3_hold_valid", out_valid_a, 1);
            chk("t3_hold_in_ready", in_ready_a, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
        chk("t3_released", out_valid_a, 0);
        push(1); push(2); push(3); push(4);
        chk("t3_next_acc", out_acc_a, 10);
        chk("t3_next_valid", out_valid_a, 1);
        idle_cycle();

        // Sparse input: one beat every three cycles
        push(9); idle_cycle(); idle_cycle();
        push(6); idle_cycle(); idle_cycle();
        push(9); idle_cycle(); idle_cycle();
        chk("t4_gap_no_valid", out_valid_a, 0);
        push(8);
        chk("t4_out_valid", out_valid_a, 1);
        chk("t4_out_acc", out_acc_a, 32);
        idle_cycle();

        // Asynchronous reset in the middle of a block
        push(3); push(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_acc", out_acc_a, 0);
        chk("t5_async_valid", out_valid_a, 0);
        chk("t5_async_ovf", out_ovf_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1); push(2); push(3); push(4);
        chk("t5_after_acc", out_acc_a, 10);
        chk("t5_after_valid", out_valid_a, 1);
        idle_cycle();

        // Clear with a simultaneous input beat that must be dropped
        push(1); push(1); push(1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_sum   = 15;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_valid", out_valid_a, 0);
        chk("t6_clr_in_ready", in_ready_a, 1);
        push(2); push(2); push(2);
        chk("t6_cnt_cleared", out_valid_a, 0);
        push(2);
        chk("t6_out_acc", out_acc_a, 8);
        chk("t6_out_valid", out_valid_a, 1);
        idle_cycle();

        // Single-sum blocks
        out_ready_c = 1'b1;
        in_valid_c  = 1'b1;
        in_sum_c    = 9;
        @(posedge clk);
        #1;
        in_valid_c = 1'b0;
        chk("c1_out_valid", out_valid_c, 1);
        chk("c1_out_acc", out_acc_c, 9);
        chk("c1_in_ready", in_ready_c, 0);
        idle_cycle();
        chk("c1_drain", out_valid_c, 0);
        in_valid_c = 1'b1;
        in_sum_c   = 5;
        @(posedge clk);
        #1;
        in_valid_c = 1'b0;
        chk("c1_second_acc", out_acc_c, 5);
        chk("c1_second_ovf", out_ovf_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
